// File: rtl/datapath_src_mux42_sched.sv
// Job sequencer for the 4-source/2-output operand-pair mux: holds the pair select per job and
// passes exactly cmd_len beats downstream. Optional stall counter: DATAPATH_SRC_MUX42_SCHED_PERF_EN.
module datapath_src_mux42_sched #(
    parameter int LEN_W = 16,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_sel,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [ID_W-1:0]  cmd_id,
    output logic [1:0]       mux_sel,
    input  logic             mux_z_valid,
    output logic             mux_z_ready,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic             busy,
    output logic             done_pulse,
    output logic [ID_W-1:0]  done_id,
`ifdef DATAPATH_SRC_MUX42_SCHED_PERF_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic             err_len0
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [LEN_W-1:0]  cnt_r;
    logic [LEN_W-1:0]  cnt_next_s;
    logic [ID_W-1:0]   cur_id_r;
    logic [1:0]        mux_sel_r;
    logic              busy_r;
    logic              done_pulse_r;
    logic [ID_W-1:0]   done_id_r;
    logic              err_len0_r;

    logic              beat_fire_s;
    logic              last_beat_s;
    logic              cmd_ready_s;
    logic              cmd_fire_s;
    logic              len_zero_s;
    logic              load_s;
    logic              mux_z_ready_s;
    logic              dn_valid_s;

    // Handshake decode; a new job may only load when no beat of the old select is pending.
    always_comb begin
        beat_fire_s   = 1'b0;
        last_beat_s   = 1'b0;
        cmd_ready_s   = 1'b0;
        mux_z_ready_s = 1'b0;
        dn_valid_s    = 1'b0;
        case (state_r)
            IDLE: begin
                cmd_ready_s = 1'b1;
            end
            RUN: begin
                mux_z_ready_s = dn_ready;
                dn_valid_s    = mux_z_valid;
                beat_fire_s   = mux_z_valid & dn_ready;
                last_beat_s   = beat_fire_s & (cnt_r == {LEN_W{1'b0}});
                cmd_ready_s   = last_beat_s;
            end
            default: begin
                cmd_ready_s = 1'b0;
            end
        endcase
        len_zero_s = (cmd_len == {LEN_W{1'b0}});
        cmd_fire_s = cmd_valid & cmd_ready_s;
        load_s     = cmd_fire_s & ~len_zero_s;
    end

    // Next-state and beat counter: counter holds beats remaining after the current one.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_beat_s && !load_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (load_s) begin
            cnt_next_s = cmd_len - LEN_W'(1);
        end else if (beat_fire_s && !last_beat_s) begin
            cnt_next_s = cnt_r - LEN_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Sequencer state, job context and completion/status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {LEN_W{1'b0}};
            cur_id_r     <= {ID_W{1'b0}};
            mux_sel_r    <= 2'b00;
            busy_r       <= 1'b0;
            done_pulse_r <= 1'b0;
            done_id_r    <= {ID_W{1'b0}};
            err_len0_r   <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            cnt_r        <= cnt_next_s;
            busy_r       <= (state_next_s == RUN);
            done_pulse_r <= last_beat_s;
            if (load_s) begin
                cur_id_r  <= cmd_id;
                mux_sel_r <= cmd_sel;
            end
            if (last_beat_s) begin
                done_id_r <= cur_id_r;
            end
            if (cmd_fire_s && len_zero_s) begin
                err_len0_r <= 1'b1;
            end
        end
    end

`ifdef DATAPATH_SRC_MUX42_SCHED_PERF_EN
    logic [31:0] stall_cnt_r;
    logic        stall_s;

    // Saturating count of starved or backpressured RUN cycles, restarted per job from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (load_s && (state_r == IDLE)) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_s   = (state_r == RUN) & (~mux_z_valid | ~dn_ready);
    assign stall_cnt = stall_cnt_r;
`endif

    assign cmd_ready   = cmd_ready_s;
    assign mux_z_ready = mux_z_ready_s;
    assign dn_valid    = dn_valid_s;
    assign mux_sel     = mux_sel_r;
    assign busy        = busy_r;
    assign done_pulse  = done_pulse_r;
    assign done_id     = done_id_r;
    assign err_len0    = err_len0_r;

endmodule

// File: tb/tb_datapath_src_mux42_sched.sv
// Directed plus random bench for datapath_src_mux42_sched against a job-level reference model.
module tb_datapath_src_mux42_sched;

    localparam int LEN_W = 16;
    localparam int ID_W  = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_sel = 2'b00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [ID_W-1:0]  cmd_id = '0;
    logic [1:0]       mux_sel;
    logic             mux_z_valid = 1'b0;
    logic             mux_z_ready;
    logic             dn_valid;
    logic             dn_ready = 1'b0;
    logic             busy;
    logic             done_pulse;
    logic [ID_W-1:0]  done_id;
    logic             err_len0;
`ifdef DATAPATH_SRC_MUX42_SCHED_PERF_EN
    logic [31:0]      stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: job-level view (beats left including the current one).
    bit        m_active;
    int        m_rem;
    bit [1:0]  m_sel;
    bit [3:0]  m_id;
    bit        m_done;
    bit [3:0]  m_done_id;
    bit        m_err;
    longint    m_stall;

    datapath_src_mux42_sched #(.LEN_W(LEN_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_len(cmd_len), .cmd_id(cmd_id),
        .mux_sel(mux_sel), .mux_z_valid(mux_z_valid), .mux_z_ready(mux_z_ready),
        .dn_valid(dn_valid), .dn_ready(dn_ready),
        .busy(busy), .done_pulse(done_pulse), .done_id(done_id),
`ifdef DATAPATH_SRC_MUX42_SCHED_PERF_EN
        .stall_cnt(stall_cnt),
`endif
        .err_len0(err_len0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_rem = 0; m_sel = 0; m_id = 0;
        m_done = 0; m_done_id = 0; m_err = 0; m_stall = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, step past the rising edge.
    task automatic step();
        bit beat, last, exp_rdy, fire;
        @(negedge clk);
        beat    = m_active && mux_z_valid && dn_ready;
        last    = beat && (m_rem == 1);
        exp_rdy = !m_active || last;
        chk("cmd_ready",   {31'd0, cmd_ready},   {31'd0, exp_rdy});
        chk("mux_z_ready", {31'd0, mux_z_ready}, {31'd0, m_active && dn_ready});
        chk("dn_valid",    {31'd0, dn_valid},    {31'd0, m_active && mux_z_valid});
        chk("busy",        {31'd0, busy},        {31'd0, m_active});
        chk("done_pulse",  {31'd0, done_pulse},  {31'd0, m_done});
        chk("done_id",     {28'd0, done_id},     {28'd0, m_done_id});
        chk("err_len0",    {31'd0, err_len0},    {31'd0, m_err});
        if (m_active || m_done) chk("mux_sel", {30'd0, mux_sel}, {30'd0, m_sel});
`ifdef DATAPATH_SRC_MUX42_SCHED_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall[31:0]);
`endif
        fire   = cmd_valid && exp_rdy;
        m_done = last;
        if (last) m_done_id = m_id;
        if (m_active && (!mux_z_valid || !dn_ready) && m_stall < 64'hFFFF_FFFF) m_stall++;
        if (beat) m_rem--;
        if (fire && cmd_len == 0) m_err = 1;
        if (fire && cmd_len != 0) begin
            if (!m_active) m_stall = 0;
            m_active = 1; m_rem = int'(cmd_len); m_sel = cmd_sel; m_id = cmd_id;
        end else if (m_active && m_rem == 0) begin
            m_active = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] s, input int len, input logic [3:0] id);
        cmd_valid = 1'b1; cmd_sel = s; cmd_len = LEN_W'(len); cmd_id = id;
    endtask

    initial begin
        model_reset();
        #12;
        // reset-state values while held in reset
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_mux_sel", {30'd0, mux_sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: sel=01 len=4 id=3, free-flowing
        mux_z_valid = 1'b1; dn_ready = 1'b1;
        cmd(2'b01, 4, 4'd3); step();
        cmd_valid = 1'b0;
        chk("t1_mux_sel", {30'd0, mux_sel}, 32'd1);
        repeat (6) step();

        // 2: len=3 with dn_ready toggling
        cmd(2'b10, 3, 4'd5); step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dn_ready = (i % 2 == 0);
            step();
        end
        dn_ready = 1'b1;
        repeat (2) step();

        // 3: back-to-back chaining, B held valid until it lands on A's last beat
        cmd(2'b00, 2, 4'd1); step();
        cmd(2'b11, 2, 4'd2); step(); step();
        cmd_valid = 1'b0;
        chk("t3_mux_sel", {30'd0, mux_sel}, 32'd3);
        chk("t3_busy", {31'd0, busy}, 32'd1);
        repeat (4) step();

        // 4: zero-length command
        cmd(2'b10, 0, 4'd7); step();
        cmd_valid = 1'b0;
        chk("t4_err", {31'd0, err_len0}, 32'd1);
        chk("t4_mux_sel", {30'd0, mux_sel}, 32'd3);
        repeat (2) step();

        // 5: reset mid-job after 2 of 5 beats
        cmd(2'b01, 5, 4'd9); step();
        cmd_valid = 1'b0;
        step(); step();
        rst_n = 1'b0; #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_mux_sel", {30'd0, mux_sel}, 32'd0);
        chk("t5_err", {31'd0, err_len0}, 32'd0);
        chk("t5_done", {31'd0, done_pulse}, 32'd0);
        chk("t5_mzr", {31'd0, mux_z_ready}, 32'd0);
        chk("t5_dnv", {31'd0, dn_valid}, 32'd0);
        chk("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cmd(2'b10, 1, 4'd4); step();
        cmd_valid = 1'b0;
        repeat (3) step();

        // 6: starved for 3 cycles before two beats
        mux_z_valid = 1'b0;
        cmd(2'b11, 2, 4'd6); step();
        cmd_valid = 1'b0;
        repeat (3) step();
        mux_z_valid = 1'b1;
        repeat (3) step();
`ifdef DATAPATH_SRC_MUX42_SCHED_PERF_EN
        chk("t6_stall", stall_cnt, 32'd3);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid   = ($urandom_range(0, 3) == 0);
            cmd_sel     = 2'($urandom_range(0, 3));
            cmd_len     = LEN_W'(($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 5));
            cmd_id      = 4'($urandom_range(0, 15));
            mux_z_valid = ($urandom_range(0, 3) != 0);
            dn_ready    = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
